// File: rtl/recop_pkt_tx.sv
// ReCOP-to-Nios packet transmitter: queues (addr, data) packets and presents each
// on the receive lines with a timed pk_detect strobe followed by a mandatory gap.
module recop_pkt_tx #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        send_valid,
   input  logic [7:0]  send_addr,
   input  logic [31:0] send_data,
   output logic        send_ready,
   input  logic        ovf_clr,
   output logic        pk_detect,
   output logic [7:0]  recv_addr,
   output logic [31:0] recv_data,
   output logic        busy,
   output logic        overflow
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CNTW-1:0] FULL    = CNTW'(DEPTH);
   localparam logic [TW-1:0]   HOLD_LD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0]   GAP_LD  = TW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            pk_q, pk_d;
   logic [7:0]      addr_q, addr_d;
   logic [31:0]     data_q, data_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic            push, pop;

   logic [7:0]      mem_addr [DEPTH];
   logic [31:0]     mem_data [DEPTH];

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pk_d     = pk_q;
      addr_d   = addr_q;
      data_d   = data_q;
      pop      = 1'b0;
      // Acceptance looks only at registered occupancy, so a push while full is
      // dropped even if a pop happens on the same edge.
      push     = send_valid && (count_q != FULL);

      case (state_q)
         IDLE: begin
            if (count_q != '0) pop = 1'b1;
         end
         SETUP: begin
            state_d = HOLD;
            pk_d    = 1'b1;
            tmr_d   = HOLD_LD;
         end
         HOLD: begin
            if (tmr_q == '0) begin
               state_d = GAP;
               pk_d    = 1'b0;
               tmr_d   = GAP_LD;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         GAP: begin
            if (tmr_q == '0) begin
               if (count_q != '0) pop = 1'b1;
               else               state_d = IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         state_d  = SETUP;
         addr_d   = mem_addr[rd_ptr_q];
         data_d   = mem_data[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase

      // A dropped push beats a simultaneous clear.
      if (send_valid && !push) ovf_d = 1'b1;
      else if (ovf_clr)        ovf_d = 1'b0;
      else                     ovf_d = ovf_q;

      busy_d = (state_d != IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         tmr_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pk_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pk_q     <= pk_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr_q] <= send_addr;
         mem_data[wr_ptr_q] <= send_data;
      end
   end

   assign send_ready = (count_q != FULL);
   assign pk_detect  = pk_q;
   assign recv_addr  = addr_q;
   assign recv_data  = data_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_recop_pkt_tx.sv
// Directed bench for recop_pkt_tx: default instance plus a HOLD=1/GAP=1 instance.
module tb_recop_pkt_tx;

   logic        clk;
   logic        reset_n;
   logic        send_valid, ovf_clr;
   logic [7:0]  send_addr;
   logic [31:0] send_data;
   logic        send_ready, pk_detect, busy, overflow;
   logic [7:0]  recv_addr;
   logic [31:0] recv_data;

   logic        s2_valid, s2_clr;
   logic [7:0]  s2_addr;
   logic [31:0] s2_data;
   logic        s2_ready, pk2, busy2, ovf2;
   logic [7:0]  raddr2;
   logic [31:0] rdata2;

   int checks = 0;
   int errors = 0;

   recop_pkt_tx dut (
      .clk(clk), .reset_n(reset_n),
      .send_valid(send_valid), .send_addr(send_addr), .send_data(send_data),
      .send_ready(send_ready), .ovf_clr(ovf_clr),
      .pk_detect(pk_detect), .recv_addr(recv_addr), .recv_data(recv_data),
      .busy(busy), .overflow(overflow)
   );

   recop_pkt_tx #(.DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
      .clk(clk), .reset_n(reset_n),
      .send_valid(s2_valid), .send_addr(s2_addr), .send_data(s2_data),
      .send_ready(s2_ready), .ovf_clr(s2_clr),
      .pk_detect(pk2), .recv_addr(raddr2), .recv_data(rdata2),
      .busy(busy2), .overflow(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      for (int c = 0; c < 400 && busy; c++) tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain busy got %0b want 0", name, busy);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      send_valid = 1'b0; send_addr = '0; send_data = '0; ovf_clr = 1'b0;
      s2_valid = 1'b0; s2_addr = '0; s2_data = '0; s2_clr = 1'b0;
      repeat (3) tick();
      checks++; if (pk_detect !== 1'b0) begin errors++; $display("FAIL reset_pk got %0b want 0", pk_detect); end
      checks++; if (recv_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", recv_addr); end
      checks++; if (recv_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", recv_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
      checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", send_ready); end
      reset_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_single();
      logic exp_pk, exp_busy;
      send_addr = 8'h5A; send_data = 32'hDEADBEEF; send_valid = 1'b1;
      tick();                       // E0
      send_valid = 1'b0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         exp_pk   = (k >= 2) && (k < 18);
         exp_busy = (k < 22);
         if (k == 1) begin
            checks++;
            if (recv_addr !== 8'h5A || recv_data !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL single_recv got %h/%h want 5a/deadbeef", recv_addr, recv_data);
            end
         end
         checks++;
         if (pk_detect !== exp_pk) begin
            errors++;
            $display("FAIL single_pk E%0d got %0b want %0b", k, pk_detect, exp_pk);
         end
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL single_busy E%0d got %0b want %0b", k, busy, exp_busy);
         end
      end
      checks++;
      if (recv_addr !== 8'h5A || recv_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_hold_idle got %h/%h want 5a/deadbeef", recv_addr, recv_data);
      end
   endtask

   task automatic test_burst();
      int   nrise = 0;
      logic prev  = pk_detect;
      for (int c = 0; c < 120; c++) begin
         send_valid = (c < 6);
         send_addr  = 8'h10 + 8'(c);
         send_data  = 32'hC0DE0000 + 32'(c);
         tick();
         if (c == 4) begin
            checks++;
            if (send_ready !== 1'b0 || overflow !== 1'b0) begin
               errors++;
               $display("FAIL burst_full ready/ovf got %0b/%0b want 0/0", send_ready, overflow);
            end
         end
         if (c == 5) begin
            checks++;
            if (send_ready !== 1'b0 || overflow !== 1'b1) begin
               errors++;
               $display("FAIL burst_drop ready/ovf got %0b/%0b want 0/1", send_ready, overflow);
            end
         end
         if (pk_detect && !prev) begin
            $display("burst rx %0d addr=%h data=%h at E%0d", nrise, recv_addr, recv_data, c);
            checks++;
            if (c != 2 + 21 * nrise) begin
               errors++;
               $display("FAIL burst_spacing rise %0d at E%0d want E%0d", nrise, c, 2 + 21 * nrise);
            end
            checks++;
            if (recv_addr !== 8'h10 + 8'(nrise) || recv_data !== 32'hC0DE0000 + 32'(nrise)) begin
               errors++;
               $display("FAIL burst_order got %h/%h want %h/%h", recv_addr, recv_data,
                        8'h10 + 8'(nrise), 32'hC0DE0000 + 32'(nrise));
            end
            nrise++;
         end
         prev = pk_detect;
      end
      send_valid = 1'b0;
      checks++;
      if (nrise != 5) begin errors++; $display("FAIL burst_count got %0d want 5", nrise); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy got %0b want 0", busy); end
   endtask

   task automatic test_overflow();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow); end
      for (int c = 0; c < 6; c++) begin
         send_valid = 1'b1;
         send_addr  = 8'h30 + 8'(c);
         send_data  = 32'h0;
         ovf_clr    = (c == 5);
         tick();
         if (c == 4) begin
            checks++;
            if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", overflow); end
         end
      end
      send_valid = 1'b0; ovf_clr = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b want 1", overflow); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %0b want 0", overflow); end
      wait_idle("ovf");
   endtask

   task automatic test_wrap();
      int   pushed = 0;
      int   rx = 0;
      logic prev = pk_detect;
      for (int c = 0; c < 400 && rx < 10; c++) begin
         if (pushed < 10 && send_ready) begin
            send_valid = 1'b1;
            send_addr  = 8'(pushed);
            send_data  = 32'(pushed) * 32'h01010101;
            pushed++;
         end else begin
            send_valid = 1'b0;
         end
         tick();
         if (pk_detect && !prev) begin
            $display("wrap rx %0d addr=%h data=%h", rx, recv_addr, recv_data);
            checks++;
            if (recv_addr !== 8'(rx) || recv_data !== 32'(rx) * 32'h01010101) begin
               errors++;
               $display("FAIL wrap_pkt%0d got %h/%h want %h/%h", rx, recv_addr, recv_data,
                        8'(rx), 32'(rx) * 32'h01010101);
            end
            rx++;
         end
         prev = pk_detect;
      end
      send_valid = 1'b0;
      checks++;
      if (rx != 10) begin errors++; $display("FAIL wrap_count got %0d want 10", rx); end
      wait_idle("wrap");
   endtask

   task automatic test_fast_params();
      int   nrise = 0;
      int   rise_c = -10;
      logic prev = pk2;
      for (int c = 0; c < 30; c++) begin
         s2_valid = (c < 3);
         s2_addr  = 8'hA0 + 8'(c);
         s2_data  = 32'h55550000 + 32'(c);
         tick();
         if (pk2 && !prev) begin
            checks++;
            if (c != 2 + 3 * nrise) begin
               errors++;
               $display("FAIL fast_spacing rise %0d at E%0d want E%0d", nrise, c, 2 + 3 * nrise);
            end
            checks++;
            if (raddr2 !== 8'hA0 + 8'(nrise) || rdata2 !== 32'h55550000 + 32'(nrise)) begin
               errors++;
               $display("FAIL fast_order got %h/%h want %h/%h", raddr2, rdata2,
                        8'hA0 + 8'(nrise), 32'h55550000 + 32'(nrise));
            end
            rise_c = c;
            nrise++;
         end
         if (!pk2 && prev) begin
            checks++;
            if (c - rise_c != 1) begin
               errors++;
               $display("FAIL fast_width got %0d want 1", c - rise_c);
            end
         end
         prev = pk2;
      end
      s2_valid = 1'b0;
      checks++;
      if (nrise != 3) begin errors++; $display("FAIL fast_count got %0d want 3", nrise); end
   endtask

   task automatic test_reset_mid_hold();
      logic seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         send_valid = 1'b1;
         send_addr  = 8'hE0 + 8'(c);
         send_data  = 32'hFACE0000 + 32'(c);
         tick();
      end
      send_valid = 1'b0;
      checks++;
      if (pk_detect !== 1'b1) begin errors++; $display("FAIL midhold_start pk got %0b want 1", pk_detect); end
      repeat (6) tick();            // now in HOLD cycle 7
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (pk_detect !== 1'b0) begin errors++; $display("FAIL midhold_pk got %0b want 0", pk_detect); end
      checks++;
      if (recv_addr !== 8'h0 || recv_data !== 32'h0) begin
         errors++;
         $display("FAIL midhold_recv got %h/%h want 00/0", recv_addr, recv_data);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midhold_busy got %0b want 0", busy); end
      checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL midhold_ready got %0b want 1", send_ready); end
      repeat (2) tick();
      reset_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (pk_detect || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midhold_no_strobe activity seen after reset"); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_wrap();
      test_fast_params();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/recop_pkt_tx.md
# recop_pkt_tx

Packet transmitter that drives the ReCOP-to-Nios receive interface: `pk_detect`, 8-bit receive address, 32-bit receive data. ReCOP-side logic pushes (address, data) packets into a small FIFO. The block presents each packet on the receive lines, holds it stable, and then strobes `pk_detect` for a fixed window so polling Nios software can sample it. A mandatory gap follows each strobe so consecutive packets are always distinguishable. There is no acknowledge path, so pacing is purely by timing.

## Interface
- `DEPTH`, default 4: FIFO depth in packets. Must be a power of 2 and ≥ 2.
- `HOLD_CYCLES`, default 16: number of cycles `pk_detect` is held high per packet. Must be ≥ 1.
- `GAP_CYCLES`, default 4: number of low cycles after each strobe. Must be ≥ 1.
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `send_valid` input, 1 bit: push request.
- `send_addr` input, 8 bits: packet address.
- `send_data` input, 32 bits: packet payload.
- `send_ready` output, 1 bit: FIFO not full.
- `ovf_clr` input, 1 bit: synchronous clear of `overflow`.
- `pk_detect` output, 1 bit: packet strobe, registered.
- `recv_addr` output, 8 bits: presented address, registered.
- `recv_data` output, 32 bits: presented data, registered.
- `busy` output, 1 bit: high when the FSM is not in IDLE or the FIFO is non-empty.
- `overflow` output, 1 bit: sticky flag for a push attempted while full.

## Operation
- Reset (async assert; deassert takes effect on the next edge):
  - FIFO emptied; `send_ready` = 1.
  - `pk_detect`, `recv_addr`, `recv_data`, `busy`, `overflow` all = 0.
  - FSM in IDLE.
- Push:
  - Occurs when `send_valid` && `send_ready` at an edge.
  - `send_ready` depends only on occupancy: it is 0 exactly when count == `DEPTH`.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - `send_valid` while full: the push is dropped, FIFO is unchanged, and `overflow` is set.
  - `ovf_clr` clears `overflow`. If set and clear happen in the same cycle, set wins.
- FSM states are IDLE, SETUP, HOLD and GAP.
  - IDLE: if the FIFO is non-empty, pop the head into `recv_addr`/`recv_data` and go to SETUP.
  - SETUP: one cycle with data stable and `pk_detect` = 0. Next state is HOLD, and `pk_detect` goes high.
  - HOLD: `pk_detect` = 1 for exactly `HOLD_CYCLES` cycles. Then `pk_detect` goes low and the FSM enters GAP.
  - GAP: `pk_detect` = 0 for exactly `GAP_CYCLES` cycles. When the gap ends:
    - FIFO non-empty: pop and go to SETUP (no IDLE cycle).
    - FIFO empty: go to IDLE.
- `recv_addr`/`recv_data` change only on a pop edge. They hold the last packet indefinitely while idle.
- Down-counter width is sized to `max(HOLD_CYCLES, GAP_CYCLES)`.
- FIFO pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. Count is log2(`DEPTH`)+1 bits.
- Reset mid-packet aborts the packet immediately: `pk_detect` drops asynchronously and queued packets are lost.

## Timing
- Push at edge E0 into an empty FIFO while IDLE:
  - E1: pop; `recv_*` valid; state SETUP.
  - E2: `pk_detect` rises.
  - E2+`HOLD_CYCLES`: `pk_detect` falls.
  - E2+`HOLD_CYCLES`+`GAP_CYCLES`: end of gap.
- Push-to-strobe latency is 2 cycles.
- `recv_*` are stable at least 1 cycle before the `pk_detect` rise. They remain stable through the whole HOLD window and the whole GAP window.
- Back-to-back packet period is 1 + `HOLD_CYCLES` + `GAP_CYCLES` cycles; with defaults this is 21.
- `send_ready` updates on the edge after a push or pop. It reflects the registered count, not a combinational path.
- `busy` falls on the edge the FSM enters IDLE with the FIFO empty.

## Test plan
- Reset then single packet:
  - Stimulus: push addr 0x5A, data 0xDEADBEEF at E0.
  - Response: `recv_addr`=0x5A and `recv_data`=0xDEADBEEF at E1; `pk_detect` high E2 to E18 (16 cycles); `busy` low at E22.
- Burst of 5 pushes on consecutive cycles with `DEPTH`=4:
  - The first 4 are accepted. The 5th cycle is accepted only if a pop has occurred; otherwise it is dropped, `overflow`=1, `send_ready`=0 while count is 4.
  - Accepted packets appear in push order. Strobe rising edges are spaced exactly 21 cycles apart.
- Overflow flag:
  - `ovf_clr` pulse clears `overflow`.
  - `ovf_clr` asserted in the same cycle as a dropped push leaves `overflow`=1.
- Wrap-around: push and drain 10 packets (addr 0..9, data = addr×0x01010101).
  - All 10 are presented in order with correct values.
  - FIFO pointers wrap cleanly.
- Reset mid-HOLD:
  - Stimulus: assert `reset_n`=0 at HOLD cycle 7 with 2 packets queued.
  - Response: `pk_detect` is 0 immediately; all outputs are 0; after release, no strobe occurs without a new push.
- Parameter sweep with `HOLD_CYCLES`=1, `GAP_CYCLES`=1:
  - `pk_detect` is a 1-cycle pulse.
  - Back-to-back period is 3 cycles.
